obi_rready_buffer: RTL and testbench
====================================

# obi_rready_buffer

Parametrised OBI response buffer that lets a slave-side port with `rready` back-pressure talk to a manager-side fabric that always accepts responses. It forwards requests only while a reserved response slot is available, so every response can be absorbed. Responses are held in an internal FIFO of configurable depth with selectable fall-through or registered output. The block also exports occupancy and outstanding-transaction status and a sticky overflow flag. It sits between an `rready`-capable OBI subordinate port and any OBI crossbar or memory port.

## Interface
Parameters:
- `obi_a_chan_t`, default `logic`: OBI A-channel struct, passed through unmodified.
- `obi_r_chan_t`, default `logic`: OBI R-channel struct, buffered.
- `DEPTH`, default 2: FIFO entries and maximum reserved slots; must be ≥1.
- `FALL_THROUGH`, default 1'b1: 1 = combinational empty-FIFO bypass; 0 = registered output.
- `CntWidth`, default `$clog2(DEPTH+1)`: status counter width; derived, do not override.

Ports:
- `clk_i` in 1: clock; all state on rising edge.
- `rst_i` in 1: reset, **asynchronous, active-high**.
- `sbr_a_chan_i` in `obi_a_chan_t`: request payload.
- `sbr_req_i` in 1: request valid.
- `sbr_gnt_o` out 1: request grant.
- `sbr_r_chan_o` out `obi_r_chan_t`: FIFO head.
- `sbr_rvalid_o` out 1: FIFO head valid.
- `sbr_rready_i` in 1: response consumed.
- `mgr_a_chan_o` out `obi_a_chan_t`: equals `sbr_a_chan_i`.
- `mgr_req_o` out 1: gated request.
- `mgr_gnt_i` in 1: downstream grant.
- `mgr_r_chan_i` in `obi_r_chan_t`: downstream response.
- `mgr_rvalid_i` in 1: downstream response valid.
- `mgr_rready_o` out 1: constant 1.
- `usage_o` out `CntWidth`: FIFO entries occupied.
- `outstanding_o` out `CntWidth`: reserved slots, covering granted-not-popped requests.
- `overflow_o` out 1: sticky; set when `mgr_rvalid_i` arrives while the FIFO is full and not popping.

## Operation
- `pop` = `sbr_rvalid_o & sbr_rready_i`. `push` = `mgr_rvalid_i`, accepted into the FIFO unless bypassed.
- `room` = (`outstanding` < DEPTH) | `pop`.
- `mgr_req_o` = `sbr_req_i & room`. `sbr_gnt_o` = `mgr_gnt_i & room`. `take` = `mgr_req_o & mgr_gnt_i`.
- `outstanding` next value:
  - +1 on `take` alone.
  - −1 on `pop` alone.
  - Unchanged on both or neither.
  - Saturates at 0; a pop at 0 does not underflow. This covers responses arriving after a reset mid-operation.
- FIFO is a circular buffer with read/write pointers wrapping modulo DEPTH, plus a count `usage`.
  - `FALL_THROUGH`=1 and FIFO empty: `sbr_rvalid_o`=`mgr_rvalid_i` and `sbr_r_chan_o`=`mgr_r_chan_i`.
  - If that fall-through response is also popped in the same cycle, nothing is written.
  - Simultaneous push and pop on a non-empty FIFO: `usage` unchanged, both pointers advance.
- Overflow case (`push`, `usage`==DEPTH, no pop): the incoming beat is dropped, `overflow_o` is set until reset, and FIFO contents are preserved. This is a protocol error by the downstream and must never occur in legal traffic.
- Nothing is forwarded to the manager without a reserved slot, so a slave stalling `sbr_rready_i` indefinitely never loses data.

## Timing
- Reset values: `sbr_gnt_o`=0 (given `mgr_gnt_i` low), `sbr_rvalid_o`=0, `mgr_req_o`=`sbr_req_i` (room=1), `mgr_rready_o`=1, `usage_o`=0, `outstanding_o`=0, `overflow_o`=0. Pointers are zero.
- Request path is purely combinational with 0 cycles of latency.
- Response latency:
  - `FALL_THROUGH`=1, FIFO empty: 0 cycles.
  - `FALL_THROUGH`=0: 1 cycle; `sbr_rvalid_o` is driven from FIFO state only.
- `sbr_rvalid_o` stays high, and `sbr_r_chan_o` stays stable, until `pop`.
- Full throughput: with `sbr_rready_i`=1 and DEPTH≥1, one request per cycle is sustained when the downstream answers in 1 cycle and `FALL_THROUGH`=1. With `FALL_THROUGH`=0 this needs DEPTH≥2.
- Status outputs are registered and reflect state after the last edge.

## Structure
- Channel types come from the existing OBI typedef macros in the shared OBI package. No new package typedefs are needed.
- One natural sub-module: `obi_rready_fifo`, which holds the circular buffer, `usage`, the bypass mux, and overflow detection.
- The credit counter and request gating live in the top module.

## Test plan
- DEPTH=2, FALL_THROUGH=1, `sbr_rready_i`=0, `mgr_gnt_i`=1, `sbr_req_i`=1 for 4 cycles, downstream responds 1 cycle after grant → exactly 2 grants; `mgr_req_o`=0 from cycle 2; `outstanding_o`=2, `usage_o`=2.
- Continue the previous case, raise `sbr_rready_i` for 1 cycle → 1 pop and 1 grant in that same cycle; `outstanding_o` stays 2.
- FALL_THROUGH=1, empty FIFO, `mgr_rvalid_i`=1 with data 0xA5 and `sbr_rready_i`=1 → `sbr_r_chan_o`=0xA5 in the same cycle; `usage_o` stays 0.
- FALL_THROUGH=0, DEPTH=4, 10 back-to-back requests with random `sbr_rready_i` → responses in order; `outstanding_o` never exceeds 4; `overflow_o`=0.
- Force `mgr_rvalid_i` while `usage_o`=DEPTH and no pop → `overflow_o`=1 next cycle and stays high; head data unchanged.
- Assert `rst_i` with `outstanding_o`=2, then deliver 2 stale responses and pop them → counters read 0 throughout; no underflow to all-ones.

Source files
------------

// File: rtl/obi_rready_buffer_pkg.sv
// Shared helpers for the OBI rready response buffer.
// Latency: none (compile-time helpers only).
// Backpressure: not applicable.
package obi_rready_buffer_pkg;

    // Width of a pointer into a buffer of the given depth. Never zero, so a
    // single-entry buffer still has a legal (constant) pointer register.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/obi_rready_fifo.sv
// Circular response buffer with optional empty-FIFO bypass and sticky overflow flag.
// Latency: 0 cycles when FALL_THROUGH=1 and empty, otherwise 1 cycle.
// Backpressure: head held stable while ready_i is low; a push into a full, non-popping buffer is dropped.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i, data_i    incoming response beat (never stalled)
//   valid_o, data_o   buffer head, consumed when ready_i is high
//   usage_o           registered entry count
//   overflow_o        sticky: a beat arrived while full and not popping
module obi_rready_fifo
    import obi_rready_buffer_pkg::*;
#(
    parameter type         data_t       = logic,
    parameter int unsigned DEPTH        = 2,
    parameter bit          FALL_THROUGH = 1'b1,
    parameter int unsigned CntWidth     = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  data_t               data_i,
    output logic                valid_o,
    output data_t               data_o,
    input  logic                ready_i,
    output logic [CntWidth-1:0] usage_o,
    output logic                overflow_o
);

    localparam int unsigned         PtrWidth = ptr_width(DEPTH);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(DEPTH - 1);
    localparam logic [CntWidth-1:0] FullCnt  = CntWidth'(DEPTH);

    data_t               mem_q [DEPTH];
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [CntWidth-1:0] usage_q;
    logic                overflow_q;

    logic empty;
    logic full;
    logic pop;
    logic bypass;
    logic write;
    logic read;

    assign empty = (usage_q == '0);
    assign full  = (usage_q == FullCnt);

    always_comb begin
        valid_o = !empty;
        data_o  = mem_q[rd_ptr_q];
        if (FALL_THROUGH && empty) begin
            valid_o = push_i;
            data_o  = data_i;
        end
    end

    assign pop    = valid_o & ready_i;
    // Beat taken straight from the input: it never touches storage.
    assign bypass = FALL_THROUGH & empty & pop;
    // When full, a pop in the same cycle frees the slot the write lands in.
    assign write  = push_i & ~bypass & (~full | pop);
    assign read   = pop & ~empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            usage_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (write) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (read) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({write, read})
                2'b10:   usage_q <= usage_q + 1'b1;
                2'b01:   usage_q <= usage_q - 1'b1;
                default: usage_q <= usage_q;
            endcase
            if (push_i && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: usage_q gates every read of it.
    always_ff @(posedge clk_i) begin
        if (write) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign usage_o    = usage_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/obi_rready_buffer.sv
// Lets an rready-capable OBI subordinate port talk to a fabric that always accepts responses.
// Latency: request path 0 cycles; response 0 cycles (fall-through, empty) or 1 cycle.
// Backpressure: requests are forwarded only while a response slot is reserved, so rready stalls never drop data.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   sbr_a_chan_i/sbr_req_i/sbr_gnt_o  subordinate-side request handshake
//   sbr_r_chan_o/sbr_rvalid_o/sbr_rready_i  subordinate-side response (buffered)
//   mgr_a_chan_o/mgr_req_o/mgr_gnt_i  manager-side request handshake (gated)
//   mgr_r_chan_i/mgr_rvalid_i/mgr_rready_o  manager-side response (always accepted)
//   usage_o, outstanding_o, overflow_o      registered status
module obi_rready_buffer
    import obi_rready_buffer_pkg::*;
#(
    parameter type         obi_a_chan_t = logic,
    parameter type         obi_r_chan_t = logic,
    parameter int unsigned DEPTH        = 2,
    parameter bit          FALL_THROUGH = 1'b1,
    parameter int unsigned CntWidth     = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  obi_a_chan_t         sbr_a_chan_i,
    input  logic                sbr_req_i,
    output logic                sbr_gnt_o,
    output obi_r_chan_t         sbr_r_chan_o,
    output logic                sbr_rvalid_o,
    input  logic                sbr_rready_i,
    output obi_a_chan_t         mgr_a_chan_o,
    output logic                mgr_req_o,
    input  logic                mgr_gnt_i,
    input  obi_r_chan_t         mgr_r_chan_i,
    input  logic                mgr_rvalid_i,
    output logic                mgr_rready_o,
    output logic [CntWidth-1:0] usage_o,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                overflow_o
);

    localparam logic [CntWidth-1:0] MaxSlots = CntWidth'(DEPTH);

    logic [CntWidth-1:0] outstanding_q;
    logic                pop;
    logic                room;
    logic                take;

    assign pop  = sbr_rvalid_o & sbr_rready_i;
    // A slot freed by this cycle's pop may be handed straight to a new request.
    assign room = (outstanding_q < MaxSlots) | pop;

    assign mgr_a_chan_o = sbr_a_chan_i;
    assign mgr_req_o    = sbr_req_i & room;
    assign sbr_gnt_o    = mgr_gnt_i & room;
    assign mgr_rready_o = 1'b1;
    assign take         = mgr_req_o & mgr_gnt_i;

    // Pops of responses whose reservation was lost to a reset leave the
    // counter at zero instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else if (take && !pop) begin
            outstanding_q <= outstanding_q + 1'b1;
        end else if (pop && !take && (outstanding_q != '0)) begin
            outstanding_q <= outstanding_q - 1'b1;
        end
    end

    assign outstanding_o = outstanding_q;

    obi_rready_fifo #(
        .data_t       (obi_r_chan_t),
        .DEPTH        (DEPTH),
        .FALL_THROUGH (FALL_THROUGH),
        .CntWidth     (CntWidth)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (mgr_rvalid_i),
        .data_i     (mgr_r_chan_i),
        .valid_o    (sbr_rvalid_o),
        .data_o     (sbr_r_chan_o),
        .ready_i    (sbr_rready_i),
        .usage_o    (usage_o),
        .overflow_o (overflow_o)
    );

endmodule

// File: tb/tb_obi_rready_buffer.sv
// Directed bench for obi_rready_buffer: a DEPTH=2 fall-through instance (a_*) and a DEPTH=4 registered instance (b_*).
// Latency: inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Backpressure: sbr_rready_i is driven directly per scenario; a 1-cycle downstream responder is modelled per instance.
module tb_obi_rready_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: DEPTH=2, FALL_THROUGH=1
    logic [7:0] a_sbr_a, a_mgr_a, a_sbr_r, a_mgr_r;
    logic       a_sbr_req, a_sbr_gnt, a_sbr_rvalid, a_sbr_rready;
    logic       a_mgr_req, a_mgr_gnt, a_mgr_rvalid, a_mgr_rready, a_overflow;
    logic [1:0] a_usage, a_outstanding;

    // Instance B: DEPTH=4, FALL_THROUGH=0
    logic [7:0] b_sbr_a, b_mgr_a, b_sbr_r, b_mgr_r;
    logic       b_sbr_req, b_sbr_gnt, b_sbr_rvalid, b_sbr_rready;
    logic       b_mgr_req, b_mgr_gnt, b_mgr_rvalid, b_mgr_rready, b_overflow;
    logic [2:0] b_usage, b_outstanding;

    obi_rready_buffer #(
        .obi_a_chan_t (logic [7:0]),
        .obi_r_chan_t (logic [7:0]),
        .DEPTH        (2),
        .FALL_THROUGH (1'b1)
    ) u_dut_a (
        .clk_i         (clk),
        .rst_i         (rst),
        .sbr_a_chan_i  (a_sbr_a),
        .sbr_req_i     (a_sbr_req),
        .sbr_gnt_o     (a_sbr_gnt),
        .sbr_r_chan_o  (a_sbr_r),
        .sbr_rvalid_o  (a_sbr_rvalid),
        .sbr_rready_i  (a_sbr_rready),
        .mgr_a_chan_o  (a_mgr_a),
        .mgr_req_o     (a_mgr_req),
        .mgr_gnt_i     (a_mgr_gnt),
        .mgr_r_chan_i  (a_mgr_r),
        .mgr_rvalid_i  (a_mgr_rvalid),
        .mgr_rready_o  (a_mgr_rready),
        .usage_o       (a_usage),
        .outstanding_o (a_outstanding),
        .overflow_o    (a_overflow)
    );

    obi_rready_buffer #(
        .obi_a_chan_t (logic [7:0]),
        .obi_r_chan_t (logic [7:0]),
        .DEPTH        (4),
        .FALL_THROUGH (1'b0)
    ) u_dut_b (
        .clk_i         (clk),
        .rst_i         (rst),
        .sbr_a_chan_i  (b_sbr_a),
        .sbr_req_i     (b_sbr_req),
        .sbr_gnt_o     (b_sbr_gnt),
        .sbr_r_chan_o  (b_sbr_r),
        .sbr_rvalid_o  (b_sbr_rvalid),
        .sbr_rready_i  (b_sbr_rready),
        .mgr_a_chan_o  (b_mgr_a),
        .mgr_req_o     (b_mgr_req),
        .mgr_gnt_i     (b_mgr_gnt),
        .mgr_r_chan_i  (b_mgr_r),
        .mgr_rvalid_i  (b_mgr_rvalid),
        .mgr_rready_o  (b_mgr_rready),
        .usage_o       (b_usage),
        .outstanding_o (b_outstanding),
        .overflow_o    (b_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream responder model: answers one cycle after each take.
    logic       a_auto = 1'b0, b_auto = 1'b0;
    logic       a_take_s = 1'b0, b_take_s = 1'b0;
    logic [7:0] a_next = 8'h10, b_next = 8'h50;

    task automatic sample();
        @(negedge clk);
        a_take_s = a_mgr_req & a_mgr_gnt;
        b_take_s = b_mgr_req & b_mgr_gnt;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
        if (a_auto) begin
            a_mgr_rvalid = a_take_s;
            a_mgr_r      = a_next;
            if (a_take_s) a_next++;
        end
        if (b_auto) begin
            b_mgr_rvalid = b_take_s;
            b_mgr_r      = b_next;
            if (b_take_s) b_next++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int pops;
        int max_out;
        int bypass_seen;

        a_sbr_a = 8'h3C; a_sbr_req = 1'b1; a_sbr_rready = 1'b0;
        a_mgr_gnt = 1'b0; a_mgr_r = 8'h00; a_mgr_rvalid = 1'b0;
        b_sbr_a = 8'hC3; b_sbr_req = 1'b0; b_sbr_rready = 1'b0;
        b_mgr_gnt = 1'b0; b_mgr_r = 8'h00; b_mgr_rvalid = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_sbr_gnt",     32'(a_sbr_gnt), 0);
        check("rst_sbr_rvalid",  32'(a_sbr_rvalid), 0);
        check("rst_mgr_req",     32'(a_mgr_req), 1);
        check("rst_mgr_rready",  32'(a_mgr_rready), 1);
        check("rst_usage",       32'(a_usage), 0);
        check("rst_outstanding", 32'(a_outstanding), 0);
        check("rst_overflow",    32'(a_overflow), 0);
        check("a_chan_pass",     32'(a_mgr_a), 32'h3C);
        rst = 1'b0;

        // Slot reservation: stalled rready, 4 cycles of requests -> 2 grants
        a_mgr_gnt = 1'b1;
        a_auto    = 1'b1;
        grants    = 0;
        for (int i = 0; i < 4; i++) begin
            sample();
            if (a_sbr_req && a_sbr_gnt) grants++;
            if (i >= 2) check("gated_mgr_req", 32'(a_mgr_req), 0);
            edge_step();
        end
        check("grant_count",     32'(grants), 2);
        check("full_outstanding", 32'(a_outstanding), 2);
        check("full_usage",      32'(a_usage), 2);

        // One pop frees a slot that is regranted in the same cycle
        a_sbr_rready = 1'b1;
        sample();
        check("pop_regrant_gnt", 32'(a_sbr_gnt), 1);
        check("pop_head_valid",  32'(a_sbr_rvalid), 1);
        check("pop_head_data",   32'(a_sbr_r), 32'h10);
        edge_step();
        a_sbr_rready = 1'b0;
        sample();
        check("regrant_outstanding", 32'(a_outstanding), 2);
        check("regrant_usage",   32'(a_usage), 1);
        edge_step();

        // Drain in order
        a_sbr_req    = 1'b0;
        a_sbr_rready = 1'b1;
        sample();
        check("drain_head0", 32'(a_sbr_r), 32'h11);
        edge_step();
        sample();
        check("drain_head1", 32'(a_sbr_r), 32'h12);
        edge_step();
        check("drain_usage",       32'(a_usage), 0);
        check("drain_outstanding", 32'(a_outstanding), 0);

        // Fall-through bypass on an empty FIFO
        a_auto       = 1'b0;
        a_mgr_rvalid = 1'b1;
        a_mgr_r      = 8'hA5;
        sample();
        check("bypass_valid", 32'(a_sbr_rvalid), 1);
        check("bypass_data",  32'(a_sbr_r), 32'hA5);
        edge_step();
        a_mgr_rvalid = 1'b0;
        check("bypass_usage",       32'(a_usage), 0);
        check("bypass_outstanding", 32'(a_outstanding), 0);

        // Overflow: push into a full FIFO with no pop
        a_sbr_rready = 1'b0;
        a_mgr_rvalid = 1'b1;
        a_mgr_r      = 8'h31;
        edge_step();
        a_mgr_r = 8'h32;
        edge_step();
        check("ovf_fill_usage", 32'(a_usage), 2);
        a_mgr_r = 8'h33;
        sample();
        check("ovf_before", 32'(a_overflow), 0);
        edge_step();
        a_mgr_rvalid = 1'b0;
        check("ovf_set",   32'(a_overflow), 1);
        check("ovf_usage", 32'(a_usage), 2);
        check("ovf_head",  32'(a_sbr_r), 32'h31);
        repeat (3) edge_step();
        check("ovf_sticky", 32'(a_overflow), 1);
        a_sbr_rready = 1'b1;
        sample();
        check("ovf_pop0", 32'(a_sbr_r), 32'h31);
        edge_step();
        sample();
        check("ovf_pop1", 32'(a_sbr_r), 32'h32);
        edge_step();
        a_sbr_rready = 1'b0;
        check("ovf_drained_usage", 32'(a_usage), 0);
        check("ovf_still_set",     32'(a_overflow), 1);
        rst = 1'b1;
        #1;
        check("ovf_cleared_by_rst", 32'(a_overflow), 0);
        edge_step();
        rst = 1'b0;

        // Registered output, DEPTH=4: 10 back-to-back requests, random rready
        b_auto      = 1'b1;
        b_sbr_req   = 1'b1;
        b_mgr_gnt   = 1'b1;
        grants      = 0;
        pops        = 0;
        max_out     = 0;
        bypass_seen = 0;
        for (int cyc = 0; cyc < 400 && pops < 10; cyc++) begin
            sample();
            if (b_sbr_req && b_sbr_gnt) grants++;
            if (b_sbr_rvalid && b_sbr_rready) begin
                check("b_order", 32'(b_sbr_r), 32'(8'h50 + 8'(pops)));
                pops++;
            end
            if (int'(b_outstanding) > max_out) max_out = int'(b_outstanding);
            if (b_mgr_rvalid && (b_usage == 3'd0) && b_sbr_rvalid) bypass_seen++;
            edge_step();
            if (grants >= 10) b_sbr_req = 1'b0;
            b_sbr_rready = 1'($urandom_range(0, 1));
        end
        check("b_pops_done",     32'(pops), 10);
        check("b_grants",        32'(grants), 10);
        check("b_max_out_le_4",  32'(max_out <= 4), 1);
        check("b_no_bypass",     32'(bypass_seen), 0);
        check("b_overflow",      32'(b_overflow), 0);
        check("b_end_outstanding", 32'(b_outstanding), 0);
        check("b_end_usage",     32'(b_usage), 0);
        b_auto       = 1'b0;
        b_mgr_rvalid = 1'b0;
        b_sbr_rready = 1'b0;

        // Reset mid-operation, then stale responses arrive and are popped
        a_sbr_req    = 1'b1;
        a_sbr_rready = 1'b0;
        sample();
        edge_step();
        sample();
        edge_step();
        a_sbr_req = 1'b0;
        check("mid_outstanding", 32'(a_outstanding), 2);
        rst = 1'b1;
        #1;
        check("mid_rst_outstanding", 32'(a_outstanding), 0);
        edge_step();
        rst = 1'b0;
        a_sbr_rready = 1'b1;
        a_mgr_rvalid = 1'b1;
        a_mgr_r      = 8'h77;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("stale_head", 32'(a_sbr_r), 32'h77);
            edge_step();
            check("stale_outstanding", 32'(a_outstanding), 0);
            check("stale_usage",       32'(a_usage), 0);
        end
        a_mgr_rvalid = 1'b0;
        edge_step();
        check("stale_final_outstanding", 32'(a_outstanding), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
